// File: rtl/iso7816_char_tx.sv
// -----------------------------------------------------------------------------
// iso7816_char_tx
//
// Transmit half of an ISO 7816-3 T=0 character link, clocked by the card clock.
// Each accepted byte goes onto the open-drain I/O line as a start bit, 8 data
// bits (direct convention, LSB first) and an even-parity bit, followed by the
// guard time. The line is released during the guard time so the receiver can
// pull it low to signal a parity error, which triggers a retransmission.
//
// Configuration macro: ISO7816_TX_RETRY_EN
//   defined   - guard-time error sampling, ERR_WAIT and the retry counter exist.
//   undefined - DATA_IN is ignored, every frame ends in TX_DONE, TX_ERROR = 0.
//
// Ports:
//   CARD_CLK  in   card clock, all logic on its rising edge
//   RESET     in   asynchronous active-high reset (releases the line at once)
//   TX_VALID  in   byte offered (only looked at while idle)
//   TX_DATA   in   byte to send, captured on accept
//   TX_READY  out  high only while idle
//   DATA_OUT  out  line value when driven
//   DATA_OE   out  1 = drive DATA_OUT onto I/O, 0 = release (pull-up high)
//   DATA_IN   in   sampled I/O line, used for error detection
//   TX_DONE   out  one-cycle pulse, character accepted by the receiver
//   TX_ERROR  out  one-cycle pulse, retries exhausted, character dropped
// -----------------------------------------------------------------------------
module iso7816_char_tx #(
    parameter int ETU_CARD_CLK_COUNT = 372,
    parameter int GUARD_ETU          = 2,
    parameter int MAX_RETRIES        = 4
) (
    input  logic       CARD_CLK,
    input  logic       RESET,
    input  logic       TX_VALID,
    input  logic [7:0] TX_DATA,
    output logic       TX_READY,
    output logic       DATA_OUT,
    output logic       DATA_OE,
    input  logic       DATA_IN,
    output logic       TX_DONE,
    output logic       TX_ERROR
);

    localparam int              ETU_W      = $clog2(ETU_CARD_CLK_COUNT);
    localparam logic [ETU_W-1:0] ETU_LAST  = ETU_W'(ETU_CARD_CLK_COUNT - 1);
    localparam logic [3:0]      LAST_BIT   = 4'd9;
    // The bit index doubles as the ETU counter for the guard and error waits.
    localparam logic [3:0]      GUARD_LAST = 4'(GUARD_ETU - 1);

    typedef enum logic [1:0] {IDLE, SEND, GUARD, ERR_WAIT} state_t;

    state_t           state_q, state_d;
    logic [ETU_W-1:0] etu_q, etu_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic             out_q, out_d;
    logic             oe_q, oe_d;
    logic             done_q, done_d;

    logic             etu_wrap;
    logic [3:0]       bit_next;
    logic [9:0]       frame_bits;

`ifdef ISO7816_TX_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               high_seen_q, high_seen_d;   // line seen released in ERR_WAIT
    logic               error_q, error_d;
`else
    logic unused_retry_cfg;
    assign unused_retry_cfg = DATA_IN ^ (MAX_RETRIES != 0);
`endif

    assign etu_wrap   = (etu_q == ETU_LAST);
    assign bit_next   = bit_q + 4'd1;
    // Index 0 is the start bit, 9 is even parity over the data bits.
    assign frame_bits = {^data_q, data_q, 1'b0};

    always_comb begin
        state_d = state_q;
        etu_d   = etu_q;
        bit_d   = bit_q;
        data_d  = data_q;
        ready_d = ready_q;
        out_d   = out_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
`ifdef ISO7816_TX_RETRY_EN
        retry_d     = retry_q;
        high_seen_d = high_seen_q;
        error_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (TX_VALID) begin
                    data_d  = TX_DATA;
                    etu_d   = '0;
                    bit_d   = 4'd0;
                    ready_d = 1'b0;
                    oe_d    = 1'b1;
                    out_d   = 1'b0;     // start bit goes out on the accept edge
                    state_d = SEND;
`ifdef ISO7816_TX_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            SEND: begin
                etu_d = etu_wrap ? '0 : etu_q + ETU_W'(1);
                if (etu_wrap) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = 4'd0;
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        state_d = GUARD;
                    end else begin
                        bit_d = bit_next;
                        out_d = frame_bits[bit_next];
                    end
                end
            end
            GUARD: begin
                etu_d = etu_wrap ? '0 : etu_q + ETU_W'(1);
                if (etu_wrap) begin
`ifdef ISO7816_TX_RETRY_EN
                    // The wrap at the end of the first guard ETU is the error sample.
                    if (bit_q == 4'd0 && !DATA_IN) begin
                        etu_d       = '0;
                        bit_d       = 4'd0;
                        high_seen_d = 1'b0;
                        state_d     = ERR_WAIT;
                    end else
`endif
                    if (bit_q == GUARD_LAST) begin
                        bit_d   = 4'd0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_next;
                    end
                end
            end
            ERR_WAIT: begin
`ifdef ISO7816_TX_RETRY_EN
                if (!high_seen_q) begin
                    // Hold the ETU timer at zero until the receiver lets go.
                    if (DATA_IN) begin
                        high_seen_d = 1'b1;
                        etu_d       = '0;
                        bit_d       = 4'd0;
                    end
                end else begin
                    etu_d = etu_wrap ? '0 : etu_q + ETU_W'(1);
                    if (etu_wrap) begin
                        if (bit_q == 4'd1) begin
                            bit_d = 4'd0;
                            if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                                retry_d = retry_q + RETRY_W'(1);
                                oe_d    = 1'b1;
                                out_d   = 1'b0;
                                state_d = SEND;
                            end else begin
                                ready_d = 1'b1;
                                error_d = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            bit_d = bit_next;
                        end
                    end
                end
`else
                ready_d = 1'b1;
                oe_d    = 1'b0;
                out_d   = 1'b1;
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CARD_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            etu_q   <= '0;
            bit_q   <= 4'd0;
            data_q  <= 8'd0;
            ready_q <= 1'b1;
            out_q   <= 1'b1;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef ISO7816_TX_RETRY_EN
            retry_q     <= '0;
            high_seen_q <= 1'b0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            etu_q   <= etu_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
`ifdef ISO7816_TX_RETRY_EN
            retry_q     <= retry_d;
            high_seen_q <= high_seen_d;
            error_q     <= error_d;
`endif
        end
    end

    assign TX_READY = ready_q;
    assign DATA_OUT = out_q;
    assign DATA_OE  = oe_q;
    assign TX_DONE  = done_q;
`ifdef ISO7816_TX_RETRY_EN
    assign TX_ERROR = error_q;
`else
    assign TX_ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_iso7816_char_tx.sv
`timescale 1ns/1ps
module tb_iso7816_char_tx;

    localparam int E         = 8;
    localparam int FRAME_LEN = 10 * E;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       data_in  = 1'b1;
    logic       tx_ready, data_out, data_oe, tx_done, tx_error;

    iso7816_char_tx #(
        .ETU_CARD_CLK_COUNT(E),
        .GUARD_ETU         (2),
        .MAX_RETRIES       (1)
    ) dut (
        .CARD_CLK(clk),
        .RESET   (rst),
        .TX_VALID(tx_valid),
        .TX_DATA (tx_data),
        .TX_READY(tx_ready),
        .DATA_OUT(data_out),
        .DATA_OE (data_oe),
        .DATA_IN (data_in),
        .TX_DONE (tx_done),
        .TX_ERROR(tx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_FRAME, EV_DONE, EV_ERROR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         at;
        logic [7:0] data;
        logic       par;
        int         len;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_t kind, input int at, input logic [7:0] data,
                        input logic par, input int len);
        exp_t e;
        e.kind = kind; e.at = at; e.data = data; e.par = par; e.len = len;
        sb.push_back(e);
    endtask

    // Monitor: decodes frames off the line and reports DONE/ERROR pulses.
    initial begin
        logic       oe_prev;
        int         f_start;
        int         nb;
        logic [9:0] fb;
        exp_t       e;
        oe_prev = 1'b0; f_start = 0; nb = 0; fb = '1;
        forever begin
            @(negedge clk);
            if (data_oe === 1'b1 && oe_prev !== 1'b1) begin
                f_start = cyc; nb = 0; fb = '1;
            end
            if (data_oe === 1'b1 && nb < 10 && ((cyc - f_start) % E) == E / 2) begin
                fb[nb] = data_out;
                nb++;
            end
            if (data_oe !== 1'b1 && oe_prev === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: start %0d len %0d, none expected", f_start, cyc - f_start);
                end else begin
                    e = sb.pop_front();
                    chk("frame_kind", 32'(e.kind), 32'(EV_FRAME));
                    chk("frame_start", 32'(f_start), 32'(e.at));
                    chk("frame_len", 32'(cyc - f_start), 32'(e.len));
                    if (e.len == FRAME_LEN) begin
                        chk("start_bit", 32'(fb[0]), 32'(0));
                        chk("frame_data", 32'(fb[8:1]), 32'(e.data));
                        chk("parity", 32'(fb[9]), 32'(e.par));
                    end
                    $display("frame start=%0d len=%0d bits=%b", f_start, cyc - f_start, fb);
                end
            end
            if (tx_done === 1'b1 || tx_error === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse: done %0d error %0d at %0d, none expected", tx_done, tx_error, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", 32'(tx_error === 1'b1 ? EV_ERROR : EV_DONE), 32'(e.kind));
                    chk("pulse_cycle", 32'(cyc), 32'(e.at));
                    chk("ready_with_pulse", 32'(tx_ready), 32'(1));
                    chk("oe_with_pulse", 32'(data_oe), 32'(0));
                    $display("pulse done=%0d error=%0d at=%0d", tx_done, tx_error, cyc);
                end
            end
            oe_prev = data_oe;
        end
    end

    // Called on a falling edge; returns on a falling edge.
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Offers a byte; t0 is the rising edge at which it is accepted.
    task automatic offer(input logic [7:0] d, input bit hold, output int t0);
        int budget;
        budget   = 0;
        t0       = -1;
        tx_data  = d;
        tx_valid = 1'b1;
        while (t0 < 0 && budget < 300) begin
            if (tx_ready === 1'b1) t0 = cyc + 1;
            @(negedge clk);
            budget++;
        end
        if (!hold) tx_valid = 1'b0;
        if (t0 < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: byte %h not accepted within %0d cycles", d, budget);
            t0 = cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // Reset state
        @(posedge clk);
        #1;
        chk("reset_ready", 32'(tx_ready), 32'(1));
        chk("reset_oe", 32'(data_oe), 32'(0));
        chk("reset_out", 32'(data_out), 32'(1));
        chk("reset_done", 32'(tx_done), 32'(0));
        chk("reset_error", 32'(tx_error), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean 0x3B: five ones, parity 1
        offer(8'h3B, 1'b0, t0);
        push(EV_FRAME, t0, 8'h3B, 1'b1, FRAME_LEN);
        push(EV_DONE, t0 + 96, 8'h00, 1'b0, 0);
        wait_cyc(t0 + 100);

`ifdef ISO7816_TX_RETRY_EN
        // One error signal, clean retransmission
        offer(8'h3B, 1'b0, t0);
        push(EV_FRAME, t0, 8'h3B, 1'b1, FRAME_LEN);
        push(EV_FRAME, t0 + 116, 8'h3B, 1'b1, FRAME_LEN);
        push(EV_DONE, t0 + 212, 8'h00, 1'b0, 0);
        wait_cyc(t0 + 83);  data_in = 1'b0;
        wait_cyc(t0 + 99);  data_in = 1'b1;
        wait_cyc(t0 + 216);

        // Error on every attempt, MAX_RETRIES=1: two frames then TX_ERROR
        offer(8'hA5, 1'b0, t0);
        push(EV_FRAME, t0, 8'hA5, 1'b0, FRAME_LEN);
        push(EV_FRAME, t0 + 116, 8'hA5, 1'b0, FRAME_LEN);
        push(EV_ERROR, t0 + 232, 8'h00, 1'b0, 0);
        wait_cyc(t0 + 83);  data_in = 1'b0;
        wait_cyc(t0 + 99);  data_in = 1'b1;
        wait_cyc(t0 + 199); data_in = 1'b0;
        wait_cyc(t0 + 215); data_in = 1'b1;
        wait_cyc(t0 + 236);
`else
        // Error signal ignored without the retry feature
        offer(8'h5A, 1'b0, t0);
        push(EV_FRAME, t0, 8'h5A, 1'b0, FRAME_LEN);
        push(EV_DONE, t0 + 96, 8'h00, 1'b0, 0);
        wait_cyc(t0 + 79);  data_in = 1'b0;
        wait_cyc(t0 + 99);  data_in = 1'b1;
        wait_cyc(t0 + 104);
`endif

        // Back-to-back with TX_VALID held; mid-frame data changes ignored
        offer(8'h00, 1'b1, t0);
        push(EV_FRAME, t0, 8'h00, 1'b0, FRAME_LEN);
        push(EV_DONE, t0 + 96, 8'h00, 1'b0, 0);
        push(EV_FRAME, t0 + 97, 8'hFF, 1'b0, FRAME_LEN);
        push(EV_DONE, t0 + 193, 8'h00, 1'b0, 0);
        wait_cyc(t0 + 20);  tx_data = 8'hFF;
        wait_cyc(t0 + 117); tx_data = 8'h55;
        wait_cyc(t0 + 150); tx_valid = 1'b0;
        wait_cyc(t0 + 200);

        // Asynchronous reset during data bit 4
        offer(8'hC3, 1'b0, t0);
        push(EV_FRAME, t0, 8'hC3, 1'b0, 43);
        wait_cyc(t0 + 42);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_oe", 32'(data_oe), 32'(0));
        chk("async_reset_ready", 32'(tx_ready), 32'(1));
        chk("async_reset_out", 32'(data_out), 32'(1));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Next byte after reset goes out normally
        offer(8'h3B, 1'b0, t0);
        push(EV_FRAME, t0, 8'h3B, 1'b1, FRAME_LEN);
        push(EV_DONE, t0 + 96, 8'h00, 1'b0, 0);
        wait_cyc(t0 + 110);

        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iso7816_char_tx.md
# iso7816_char_tx

Transmit side of the ISO 7816-3 T=0 character link, clocked by the card clock. It serialises one byte per handshake onto the open-drain I/O line as start bit, 8 data bits (direct convention, LSB first) and even parity, then holds the guard time. It checks the line for the receiver's error signal and retransmits on error. It sits alongside the APDU receive/trigger logic and drives APDU responses or commands during fault-injection and replay experiments.

## Interface
Parameters:
- ETU_CARD_CLK_COUNT, 372 — card clocks per elementary time unit (Fd/Dd); legal range ≥4.
- GUARD_ETU, 2 — ETUs from parity end to frame end; legal range ≥2.
- MAX_RETRIES, 4 — retransmissions after the first attempt before giving up.

Ports:
- CARD_CLK  in  1  card clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- TX_VALID  in  1  byte offered.
- TX_DATA  in  8  byte to send; captured on accept.
- TX_READY  out  1  high only in IDLE.
- DATA_OUT  out  1  line value when driven.
- DATA_OE  out  1  1 = drive DATA_OUT onto I/O; 0 = release (pull-up high).
- DATA_IN  in  1  sampled I/O line, used for error detection.
- TX_DONE  out  1  one-cycle pulse: character accepted by the receiver.
- TX_ERROR  out  1  one-cycle pulse: retries exhausted, character dropped.

## Operation
- States: IDLE, SEND, GUARD, ERR_WAIT.
- IDLE: TX_READY=1, DATA_OE=0. If TX_VALID=1 on an edge, latch TX_DATA, clear the retry count and ETU counter, and enter SEND.
- SEND: drives 10 bits, each lasting exactly ETU_CARD_CLK_COUNT cycles.
  - Bit 0 is the start bit, value 0.
  - Bits 1–8 are TX_DATA[0..7].
  - Bit 9 is parity, the XOR of the 8 data bits, so the total count of ones is even.
  - DATA_OE=1 throughout SEND.
- GUARD: DATA_OE=0 for GUARD_ETU ETUs. DATA_IN is sampled once, 1 ETU into GUARD. If the sample is 0, enter ERR_WAIT; otherwise, at GUARD end, pulse TX_DONE and return to IDLE.
- ERR_WAIT: wait until DATA_IN is sampled high, then wait 2 further ETUs.
  - If retry count < MAX_RETRIES: increment it and re-enter SEND with the latched byte.
  - Otherwise: pulse TX_ERROR and enter IDLE.
- TX_VALID and TX_DATA are ignored outside IDLE.
- Counter widths:
  - ETU counter: $clog2(ETU_CARD_CLK_COUNT) bits, wrapping ETU_CARD_CLK_COUNT-1 → 0.
  - Bit index: 4 bits.
  - Retry counter: $clog2(MAX_RETRIES+1) bits; must never wrap.
- Reset values: state IDLE, TX_READY=1, DATA_OE=0, DATA_OUT=1, TX_DONE=0, TX_ERROR=0, all counters 0.
- Reset mid-frame releases the line immediately, without waiting for a clock edge. No TX_DONE or TX_ERROR is produced for the aborted byte.

## Timing
- E = ETU_CARD_CLK_COUNT. T0 = the edge where TX_VALID&&TX_READY is true.
- All outputs are registered.
  - Bit k is on DATA_OUT/DATA_OE from edge T0+kE up to edge T0+(k+1)E.
  - The line is released at edge T0+10E.
- DATA_IN error sample: edge T0+11E.
- GUARD ends at edge T0+(10+GUARD_ETU)E.
  - TX_DONE=1 and TX_READY=1 for the cycle after that edge.
  - TX_DONE lasts exactly one cycle.
- Back-to-back with TX_VALID held: next T0 is one edge after the frame-end edge, giving a start-bit spacing of (10+GUARD_ETU)E+1 cycles.
- Retransmit: the start bit is driven 2E edges after the first edge at which DATA_IN is sampled high in ERR_WAIT.
- TX_ERROR is asserted at that same point instead of the start bit, and TX_READY rises with it.

## Configuration
- ISO7816_TX_RETRY_EN defined: error sampling, ERR_WAIT and the retry counter are present, as described above.
- Not defined:
  - DATA_IN is ignored and GUARD always ends in TX_DONE.
  - TX_ERROR is tied to 0 and ERR_WAIT is unreachable.
  - MAX_RETRIES has no effect.

## Test plan
With E=8, GUARD_ETU=2, macro defined unless stated:
- Reset, send 0x3B → DATA_OUT per ETU 0,1,1,0,1,1,1,0,0, then parity 1; DATA_OE falls at T0+80; DATA_IN not pulled low → TX_DONE one cycle after edge T0+96.
- Send 0x3B, DATA_IN forced 0 over edges T0+84..T0+99 → no TX_DONE; second start bit at edge T0+116; clean second attempt → TX_DONE.
- MAX_RETRIES=1, error forced on every attempt → exactly 2 start bits, TX_ERROR one-cycle pulse, TX_READY=1, DATA_OE=0.
- TX_VALID held high with 0x00 then 0xFF → start bits 97 cycles apart; parities 0 and 0; TX_DATA changes mid-frame ignored.
- RESET asserted between clock edges during data bit 4 → DATA_OE=0 and TX_READY=1 before the next edge; no TX_DONE/TX_ERROR; next byte sends normally.
- Macro undefined, DATA_IN held 0 during guard → TX_DONE at T0+96; TX_ERROR never asserted.
